moving_rect: RTL and testbench

MOVING_RECT -- requirements
Module: moving_rect

---
 rtl/moving_rect.sv | 121 ++++++++++++
 tb/tb_moving_rect.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/moving_rect.sv
// moving_rect: a rectangle that drifts left at a fixed speed and falls under
// gravity, with an optional flap impulse. Position updates once per frame
// strobe. Edges are driven combinationally from the stored centre.
// Optional feature: define MOVING_RECT_WRAP_EN to make the rectangle wrap to
// the right edge when it reaches the left edge. Without it, the rectangle
// clamps at the left edge and o_wrap is always 0.
module moving_rect #(
    parameter int X_SIZE   = 16,
    parameter int Y_SIZE   = 16,
    parameter int IX       = 320,
    parameter int IY       = 240,
    parameter int D_WIDTH  = 640,
    parameter int D_HEIGHT = 480,
    parameter int X_SPEED  = 2,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VY  = -8,
    parameter int VY_MAX   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_animate,
    input  logic        i_flap,
    input  logic        i_freeze,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic        o_wrap,
    output logic        o_ground
);

    localparam logic signed [12:0] XS_S    = 13'(X_SIZE);
    localparam logic signed [12:0] YS_S    = 13'(Y_SIZE);
    localparam logic signed [12:0] YBOT_S  = 13'(D_HEIGHT - Y_SIZE);
    localparam logic signed [12:0] XSPD_S  = 13'(X_SPEED);
    localparam logic signed [12:0] GRAV_S  = 13'(GRAVITY);
    localparam logic signed [12:0] FLAP_S  = 13'(FLAP_VY);
    localparam logic signed [12:0] VYMAX_S = 13'(VY_MAX);

    logic [11:0]        x, y;
    logic signed [11:0] vy;
    logic               flap_pend;
    logic               wrap_q, ground_q;

    logic               frame, take_flap;
    logic signed [12:0] vy_g, vy_n, y_t, x_t;
    logic [11:0]        x_nx, y_nx;
    logic signed [11:0] vy_nx;
    logic               wrap_nx, ground_nx;

    // Next-frame position, velocity and status, all in 13-bit signed
    always_comb begin
        frame     = i_animate & ~i_freeze;
        take_flap = flap_pend | i_flap;

        vy_g = {vy[11], vy} + GRAV_S;
        if (take_flap)
            vy_n = FLAP_S;
        else if (vy_g > VYMAX_S)
            vy_n = VYMAX_S;
        else
            vy_n = vy_g;

        y_t       = $signed({1'b0, y}) + vy_n;
        y_nx      = y_t[11:0];
        vy_nx     = vy_n[11:0];
        ground_nx = 1'b0;
        if (y_t < YS_S) begin
            y_nx  = YS_S[11:0];
            vy_nx = '0;
        end else if (y_t > YBOT_S) begin
            y_nx      = YBOT_S[11:0];
            vy_nx     = '0;
            ground_nx = 1'b1;
        end

        x_t     = $signed({1'b0, x}) - XSPD_S;
        x_nx    = x_t[11:0];
        wrap_nx = 1'b0;
        if (x_t < XS_S) begin
`ifdef MOVING_RECT_WRAP_EN
            x_nx    = 12'(D_WIDTH - X_SIZE);
            wrap_nx = 1'b1;
`else
            x_nx    = XS_S[11:0];
`endif
        end
    end

    // State register: flap requests latch any time, motion only on unfrozen frames
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x         <= 12'(IX);
            y         <= 12'(IY);
            vy        <= '0;
            flap_pend <= 1'b0;
            wrap_q    <= 1'b0;
            ground_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (i_flap)
                flap_pend <= 1'b1;
            if (frame) begin
                flap_pend <= 1'b0;
                x         <= x_nx;
                y         <= y_nx;
                vy        <= vy_nx;
                wrap_q    <= wrap_nx;
                ground_q  <= ground_nx;
            end
        end
    end

    assign o_x1     = x - 12'(X_SIZE);
    assign o_x2     = x + 12'(X_SIZE);
    assign o_y1     = y - 12'(Y_SIZE);
    assign o_y2     = y + 12'(Y_SIZE);
    assign o_wrap   = wrap_q;
    assign o_ground = ground_q;

endmodule

// File: tb/tb_moving_rect.sv
// Self-checking bench for moving_rect: a directed vector table on a default
// instance, a free-fall/landing sequence, and a wrap/clamp sequence on an
// instance started near the left edge (honours MOVING_RECT_WRAP_EN).
module tb_moving_rect;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_rst = 1'b1, i_animate = 1'b0, i_flap = 1'b0, i_freeze = 1'b0;
    logic [11:0] o_x1, o_x2, o_y1, o_y2;
    logic o_wrap, o_ground;

    logic w_rst = 1'b1, w_animate = 1'b0;
    logic [11:0] w_x1, w_x2, w_y1, w_y2;
    logic w_wrap, w_ground;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    moving_rect u_dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_animate(i_animate), .i_flap(i_flap),
        .i_freeze(i_freeze), .o_x1(o_x1), .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2),
        .o_wrap(o_wrap), .o_ground(o_ground)
    );

    moving_rect #(.IX(20)) u_wrap (
        .i_clk(i_clk), .i_rst(w_rst), .i_animate(w_animate), .i_flap(1'b0),
        .i_freeze(1'b0), .o_x1(w_x1), .o_x2(w_x2), .o_y1(w_y1), .o_y2(w_y2),
        .o_wrap(w_wrap), .o_ground(w_ground)
    );

    typedef struct {
        logic        rst, anim, flap, frz;
        logic [11:0] x1, x2, y1, y2;
        logic        wrap, gnd;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic f, input logic z);
        @(negedge i_clk);
        i_rst = r; i_animate = a; i_flap = f; i_freeze = z;
        @(posedge i_clk);
        #1;
    endtask

    task automatic wstep(input logic r, input logic a);
        @(negedge i_clk);
        w_rst = r; w_animate = a;
        @(posedge i_clk);
        #1;
    endtask

    int m_y, m_vy, m_g;

    initial begin
        //          rst   anim  flap  frz    x1   x2   y1   y2  wrap gnd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 302, 334, 225, 257, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 300, 332, 227, 259, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 298, 330, 230, 262, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 302, 334, 216, 248, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 300, 332, 209, 241, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 304, 336, 224, 256, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 302, 334, 216, 248, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 300, 332, 208, 240, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 304, 336, 224, 256, 1'b0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].anim, vecs[i].flap, vecs[i].frz);
            chk($sformatf("v%0d_x1", i), int'(o_x1), int'(vecs[i].x1));
            chk($sformatf("v%0d_x2", i), int'(o_x2), int'(vecs[i].x2));
            chk($sformatf("v%0d_y1", i), int'(o_y1), int'(vecs[i].y1));
            chk($sformatf("v%0d_y2", i), int'(o_y2), int'(vecs[i].y2));
            chk($sformatf("v%0d_wrap", i), int'(o_wrap), int'(vecs[i].wrap));
            chk($sformatf("v%0d_gnd", i), int'(o_ground), int'(vecs[i].gnd));
        end

        // Free fall to the floor: velocity saturates at 8, lands at y=464
        step(1'b1, 1'b0, 1'b0, 1'b0);
        m_y = 240; m_vy = 0; m_g = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
            if (m_y + m_vy > 464) begin
                m_y = 464; m_vy = 0; m_g = 1;
            end else begin
                m_y = m_y + m_vy; m_g = 0;
            end
            chk($sformatf("fall%0d_y2", i), int'(o_y2), m_y + 16);
            chk($sformatf("fall%0d_gnd", i), int'(o_ground), m_g);
            chk($sformatf("fall%0d_x1", i), int'(o_x1), 320 - 2 * (i + 1) - 16);
        end
        chk("floor_y2", int'(o_y2), 480);
        chk("floor_gnd", int'(o_ground), 1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("liftoff_y2", int'(o_y2), 472);
        chk("liftoff_gnd", int'(o_ground), 0);

        // Left edge: wrap to x=624 or clamp at x=16 depending on build
        wstep(1'b1, 1'b0);
        chk("w_rst_x1", int'(w_x1), 4);
        chk("w_rst_wrap", int'(w_wrap), 0);
        wstep(1'b0, 1'b1);
        chk("w1_x1", int'(w_x1), 2);
        chk("w1_wrap", int'(w_wrap), 0);
        wstep(1'b0, 1'b1);
        chk("w2_x1", int'(w_x1), 0);
        chk("w2_wrap", int'(w_wrap), 0);
        wstep(1'b0, 1'b1);
`ifdef MOVING_RECT_WRAP_EN
        chk("w3_x1", int'(w_x1), 608);
        chk("w3_x2", int'(w_x2), 640);
        chk("w3_wrap", int'(w_wrap), 1);
        wstep(1'b0, 1'b0);
        chk("w4_x1", int'(w_x1), 608);
        chk("w4_wrap", int'(w_wrap), 0);
        wstep(1'b0, 1'b1);
        chk("w5_x1", int'(w_x1), 606);
        chk("w5_wrap", int'(w_wrap), 0);
`else
        chk("w3_x1", int'(w_x1), 0);
        chk("w3_x2", int'(w_x2), 32);
        chk("w3_wrap", int'(w_wrap), 0);
        wstep(1'b0, 1'b1);
        chk("w4_x1", int'(w_x1), 0);
        chk("w4_wrap", int'(w_wrap), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
